// File: rtl/move_collector.sv
// Walks all 64 square FIFOs after move generation settles and unpacks each
// 48-bit word of origin slots into a stream of {from, to} moves.
module move_collector (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        gen_done,
    output logic [5:0]  sq_sel,
    input  logic        fifo_empty,
    output logic        fifo_rden,
    input  logic [47:0] fifo_data,
    output logic        mv_valid,
    input  logic        mv_ready,
    output logic [11:0] mv_data,
    output logic [7:0]  mv_count,
    output logic        busy,
    output logic        list_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GEN,
        SELECT,
        READ,
        LATCH,
        EMIT,
        NEXT,
        DONE
    } state_t;

    state_t      state_q;
    logic [5:0]  sq_q;
    logic        rden_q;
    logic [47:0] word_q;
    logic [2:0]  idx_q;
    logic        valid_q;
    logic [11:0] data_q;
    logic [7:0]  count_q;
    logic        busy_q;
    logic        done_q;

    logic [2:0]  idxNext_d;
    logic [5:0]  slotNext_d;

    // Slot examined after the current one; only meaningful while idx_q > 0.
    always_comb begin
        idxNext_d  = idx_q - 3'd1;
        slotNext_d = word_q[6*idxNext_d +: 6];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sq_q    <= 6'd0;
            rden_q  <= 1'b0;
            word_q  <= 48'd0;
            idx_q   <= 3'd7;
            valid_q <= 1'b0;
            data_q  <= 12'd0;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WAIT_GEN;
                        count_q <= 8'd0;
                        sq_q    <= 6'd0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_GEN: begin
                    if (gen_done) begin
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (fifo_empty) begin
                        state_q <= NEXT;
                    end else begin
                        state_q <= READ;
                        rden_q  <= 1'b1;
                    end
                end
                READ: begin
                    rden_q  <= 1'b0;
                    state_q <= LATCH;
                end
                // Slot 7 is judged here from the raw FIFO word so that mv_valid
                // is already correct in the first EMIT cycle.
                LATCH: begin
                    word_q  <= fifo_data;
                    idx_q   <= 3'd7;
                    valid_q <= (fifo_data[47:42] != sq_q);
                    data_q  <= {fifo_data[47:42], sq_q};
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (!valid_q || mv_ready) begin
                        if (valid_q && count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                        if (idx_q == 3'd0) begin
                            valid_q <= 1'b0;
                            state_q <= SELECT;
                        end else begin
                            idx_q   <= idxNext_d;
                            valid_q <= (slotNext_d != sq_q);
                            data_q  <= {slotNext_d, sq_q};
                        end
                    end
                end
                NEXT: begin
                    if (sq_q == 6'd63) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        sq_q    <= sq_q + 6'd1;
                        state_q <= SELECT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sq_sel    = sq_q;
    assign fifo_rden = rden_q;
    assign mv_valid  = valid_q;
    assign mv_data   = data_q;
    assign mv_count  = count_q;
    assign busy      = busy_q;
    assign list_done = done_q;

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: a table of single-word squares plus
// hand-written backpressure, multi-word, reset, start-while-busy and saturation cases.
module tb_move_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        gen_done = 1'b0;
    logic [5:0]  sq_sel;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [47:0] fifo_data = 48'd0;
    logic        mv_valid;
    logic        mv_ready = 1'b0;
    logic [11:0] mv_data;
    logic [7:0]  mv_count;
    logic        busy;
    logic        list_done;

    move_collector dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .gen_done   (gen_done),
        .sq_sel     (sq_sel),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_data  (fifo_data),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .mv_data    (mv_data),
        .mv_count   (mv_count),
        .busy       (busy),
        .list_done  (list_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sq;
        logic [47:0] word;
        int          expCount;
        logic [11:0] expFirst;
        logic [11:0] expSecond;
    } vector_t;

    vector_t     vecs [4];
    int          vectors = 0;
    int          miscompares = 0;

    // Per-square FIFO model: up to four words each.
    logic [47:0] mem [64][4];
    int          wrCnt [64];
    int          rdCnt [64];
    logic [11:0] moves [$];
    int          rdenCount = 0;
    int          rdenBad = 0;
    int          listDoneCount = 0;
    logic [5:0]  rdenSqLast = 6'd0;

    assign fifo_empty = (rdCnt[sq_sel] >= wrCnt[sq_sel]);

    // Monitor samples mid-cycle; the popped word is presented during READ and
    // stays valid through LATCH.
    always @(negedge clk) begin
        if (fifo_rden) begin
            rdenCount++;
            rdenSqLast = sq_sel;
            if (fifo_empty) begin
                rdenBad++;
            end else begin
                fifo_data = mem[sq_sel][rdCnt[sq_sel]];
                rdCnt[sq_sel]++;
            end
        end
        if (mv_valid && mv_ready) moves.push_back(mv_data);
        if (list_done) listDoneCount++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [11:0] moveAt(input int i);
        return (i < moves.size()) ? moves[i] : 12'hFFF;
    endfunction

    task automatic clearFifos();
        for (int s = 0; s < 64; s++) begin
            wrCnt[s] = 0;
            rdCnt[s] = 0;
        end
        moves.delete();
        rdenCount = 0;
        rdenBad = 0;
        listDoneCount = 0;
    endtask

    task automatic resetDut();
        start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // cycles counts the start cycle as 1 and ends on the cycle list_done is high.
    task automatic runPass(input int budget, output int cycles, output bit seen);
        start  = 1'b1;
        cycles = 1;
        seen   = 1'b0;
        step();
        start = 1'b0;
        while (!seen && cycles < budget) begin
            cycles++;
            if (list_done) seen = 1'b1;
            else step();
        end
    endtask

    task automatic waitValid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (mv_valid) seen = 1'b1;
            else step();
        end
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        int cycles;
        bit seen;
        resetDut();
        clearFifos();
        mem[v.sq][0] = v.word;
        wrCnt[v.sq]  = 1;
        mv_ready = 1'b1;
        gen_done = 1'b1;
        runPass(1000, cycles, seen);
        checkOutput($sformatf("vec%0d list_done", idx), 64'(seen), 64'd1);
        checkOutput($sformatf("vec%0d mv_count", idx), 64'(mv_count), 64'(v.expCount));
        checkOutput($sformatf("vec%0d moves", idx), 64'(moves.size()), 64'(v.expCount));
        if (v.expCount >= 1) checkOutput($sformatf("vec%0d move0", idx), 64'(moveAt(0)), 64'(v.expFirst));
        if (v.expCount >= 2) checkOutput($sformatf("vec%0d move1", idx), 64'(moveAt(1)), 64'(v.expSecond));
        checkOutput($sformatf("vec%0d rden_empty", idx), 64'(rdenBad), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cycles;
        bit seen;
        int r0;

        vecs[0] = '{sq: 6'h0A, word: {6'h02, 6'h12, {6{6'h0A}}}, expCount: 2, expFirst: 12'h08A, expSecond: 12'h48A};
        vecs[1] = '{sq: 6'h00, word: 48'd0, expCount: 0, expFirst: 12'h000, expSecond: 12'h000};
        vecs[2] = '{sq: 6'h3F, word: {{7{6'h3F}}, 6'h01}, expCount: 1, expFirst: 12'h07F, expSecond: 12'h000};
        vecs[3] = '{sq: 6'h15, word: {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7},
                    expCount: 8, expFirst: 12'h015, expSecond: 12'h055};

        // Reset state, then the all-empty pass timing.
        clearFifos();
        resetDut();
        checkOutput("rst sq_sel", 64'(sq_sel), 64'd0);
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst mv_valid", 64'(mv_valid), 64'd0);
        checkOutput("rst mv_data", 64'(mv_data), 64'd0);
        checkOutput("rst mv_count", 64'(mv_count), 64'd0);
        checkOutput("rst list_done", 64'(list_done), 64'd0);
        gen_done = 1'b1;
        mv_ready = 1'b1;
        runPass(400, cycles, seen);
        checkOutput("empty list_done", 64'(seen), 64'd1);
        checkOutput("empty latency", 64'(cycles), 64'(1 + 1 + 64 * 2 + 1));
        checkOutput("empty mv_count", 64'(mv_count), 64'd0);
        checkOutput("empty rden", 64'(rdenCount), 64'd0);
        step();
        checkOutput("empty pulse", 64'(list_done), 64'd0);
        checkOutput("empty busy", 64'(busy), 64'd0);
        checkOutput("empty pulses", 64'(listDoneCount), 64'd1);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

        // Backpressure holds the first move stable.
        resetDut();
        clearFifos();
        mem[6'h0A][0] = vecs[0].word;
        wrCnt[6'h0A]  = 1;
        mv_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        waitValid(300, seen);
        checkOutput("bp valid", 64'(seen), 64'd1);
        r0 = rdenCount;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp hold valid %0d", i), 64'(mv_valid), 64'd1);
            checkOutput($sformatf("bp hold data %0d", i), 64'(mv_data), 64'h08A);
            step();
        end
        checkOutput("bp rden", 64'(rdenCount), 64'(r0));
        mv_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (list_done) seen = 1'b1;
            else step();
        end
        checkOutput("bp list_done", 64'(seen), 64'd1);
        checkOutput("bp moves", 64'(moves.size()), 64'd2);
        checkOutput("bp move0", 64'(moveAt(0)), 64'h08A);
        checkOutput("bp move1", 64'(moveAt(1)), 64'h48A);
        checkOutput("bp mv_count", 64'(mv_count), 64'd2);

        // Square 63 holds two words; both drain before the pass ends.
        resetDut();
        clearFifos();
        mem[63][0] = {6'h00, {7{6'h3F}}};
        mem[63][1] = {{7{6'h3F}}, 6'h05};
        wrCnt[63]  = 2;
        runPass(1000, cycles, seen);
        checkOutput("sq63 list_done", 64'(seen), 64'd1);
        checkOutput("sq63 rden", 64'(rdenCount), 64'd2);
        checkOutput("sq63 rden_sq", 64'(rdenSqLast), 64'd63);
        checkOutput("sq63 sq_sel", 64'(sq_sel), 64'd63);
        checkOutput("sq63 moves", 64'(moves.size()), 64'd2);
        checkOutput("sq63 move0", 64'(moveAt(0)), 64'h03F);
        checkOutput("sq63 move1", 64'(moveAt(1)), 64'h17F);
        checkOutput("sq63 mv_count", 64'(mv_count), 64'd2);

        // Reset while a move is pending.
        resetDut();
        clearFifos();
        mem[6'h0A][0] = vecs[0].word;
        wrCnt[6'h0A]  = 1;
        mv_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        waitValid(300, seen);
        checkOutput("mid valid", 64'(seen), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("mid sq_sel", 64'(sq_sel), 64'd0);
        checkOutput("mid mv_valid", 64'(mv_valid), 64'd0);
        checkOutput("mid mv_data", 64'(mv_data), 64'd0);
        checkOutput("mid busy", 64'(busy), 64'd0);
        checkOutput("mid fifo_rden", 64'(fifo_rden), 64'd0);
        checkOutput("mid list_done", 64'(list_done), 64'd0);
        gen_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("mid restart busy", 64'(busy), 64'd1);
        checkOutput("mid restart sq_sel", 64'(sq_sel), 64'd0);

        // Start while busy is ignored; SELECT follows gen_done by one cycle.
        resetDut();
        clearFifos();
        mem[0][0] = {6'h01, {7{6'h00}}};
        wrCnt[0]  = 1;
        gen_done = 1'b0;
        mv_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step(3);
        start = 1'b1;
        step();
        start = 1'b0;
        step(5);
        checkOutput("wg busy", 64'(busy), 64'd1);
        checkOutput("wg rden", 64'(rdenCount), 64'd0);
        gen_done = 1'b1;
        step();
        checkOutput("wg select rden", 64'(fifo_rden), 64'd0);
        step();
        checkOutput("wg read rden", 64'(fifo_rden), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (list_done) seen = 1'b1;
            else step();
        end
        checkOutput("wg list_done", 64'(seen), 64'd1);
        checkOutput("wg move0", 64'(moveAt(0)), 64'h040);
        checkOutput("wg mv_count", 64'(mv_count), 64'd1);
        step();
        checkOutput("wg pulses", 64'(listDoneCount), 64'd1);
        checkOutput("wg idle", 64'(busy), 64'd0);

        // 33 full squares give 264 moves; the counter stops at 255.
        resetDut();
        clearFifos();
        for (int s = 0; s < 33; s++) begin
            logic [5:0] v;
            v = 6'(s) ^ 6'h01;
            mem[s][0] = {8{v}};
            wrCnt[s]  = 1;
        end
        runPass(3000, cycles, seen);
        checkOutput("sat list_done", 64'(seen), 64'd1);
        checkOutput("sat moves", 64'(moves.size()), 64'd264);
        checkOutput("sat mv_count", 64'(mv_count), 64'd255);
        checkOutput("sat rden_empty", 64'(rdenBad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse; begins a collection pass over all 64 square units.
REQ-004 gen_done  input  1  AND of all square-unit done flags; high when move generation has settled.
REQ-005 sq_sel  output  6  selected square {x[2:0], y[2:0]}; drives the external FIFO read mux.
REQ-006 fifo_empty  input  1  empty flag of the selected square's FIFO; valid combinationally for the current sq_sel.
REQ-007 fifo_rden  output  1  one-cycle read strobe to the selected square's FIFO.
REQ-008 fifo_data  input  48  selected FIFO word, valid exactly 1 cycle after fifo_rden; eight 6-bit origin slots, slot 7 = [47:42] … slot 0 = [5:0].
REQ-009 mv_valid  output  1  mv_data holds a move.
REQ-010 mv_ready  input  1  downstream accepts a move.
REQ-011 mv_data  output  12  {from[5:0], to[5:0]}; from = slot value, to = sq_sel at read time.
REQ-012 mv_count  output  8  number of moves accepted in the current or last pass.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 list_done  output  1  one-cycle pulse at end of pass.

Function
REQ-015 FSM states: IDLE, WAIT_GEN, SELECT, READ, LATCH, EMIT, NEXT, DONE.
REQ-016 IDLE: start=1 -> WAIT_GEN; clear mv_count; sq_sel=0.
REQ-017 WAIT_GEN: remain until gen_done=1, then -> SELECT.
REQ-018 SELECT: one cycle; fifo_empty=1 -> NEXT; otherwise -> READ.
REQ-019 READ: fifo_rden=1 for exactly this cycle -> LATCH.
REQ-020 LATCH: capture fifo_data into a 48-bit word register; slot index=7 -> EMIT.
REQ-021 EMIT: examine slot[index]; a slot equal to sq_sel is padding and is skipped with no mv_valid, costing one cycle.
REQ-022 EMIT, non-padding slot: mv_valid=1, mv_data={slot, sq_sel}; hold until mv_valid&&mv_ready, then advance index.
REQ-023 mv_data and mv_valid SHALL stay constant while mv_valid=1 and mv_ready=0.
REQ-024 After slot 0 is processed -> SELECT with the same sq_sel, so the FIFO drains completely before moving on.
REQ-025 NEXT: sq_sel=63 -> DONE; otherwise sq_sel+1 -> SELECT.
REQ-026 DONE: list_done=1 for one cycle -> IDLE; mv_count holds its final value until the next start.
REQ-027 mv_count increments on each accepted transfer and saturates at 255.
REQ-028 start outside IDLE is ignored.
REQ-029 gen_done is sampled only in WAIT_GEN.
REQ-030 fifo_rden SHALL never be asserted while fifo_empty=1 or outside READ.
REQ-031 mv_ready while mv_valid=0 has no effect.

Reset
REQ-032 reset=1 at any clock edge, including mid-pass or with a transfer pending: state=IDLE, sq_sel=0, fifo_rden=0, mv_valid=0, mv_data=0, mv_count=0, busy=0, list_done=0, slot index=7, word register=0.
REQ-033 reset has priority over start and over all handshakes.
REQ-034 A FIFO read in flight is discarded on reset.

Verification
REQ-035 All 64 FIFOs empty, start, gen_done=1 -> list_done pulses 1+1+64×2+1 cycles after start (IDLE, WAIT_GEN, SELECT/NEXT per square, DONE); mv_count=0; fifo_rden never high.
REQ-036 Square 0x0A FIFO holds one word with slot7=0x02 and slot6=0x12, remaining slots=0x0A; mv_ready=1 -> exactly two moves, 0x08A then 0x48A; mv_count=2.
REQ-037 Same stimulus, mv_ready held low 5 cycles -> mv_valid stays high and mv_data stays 0x08A for 5 cycles; no rden; second move follows after mv_ready rises.
REQ-038 Square 63 FIFO holds two words -> two rden pulses at sq_sel=63, both words unpacked, then list_done; sq_sel does not wrap past 63 within the pass.
REQ-039 reset asserted during EMIT with mv_valid=1 -> next cycle all outputs are at their reset values; a subsequent start begins at sq_sel=0.
REQ-040 start pulse while busy and gen_done held low for 10 cycles -> FSM stays in WAIT_GEN, second start ignored, SELECT entered one cycle after gen_done rises.
